ctl_round: RTL and testbench

//  Game sequencer for Duck Hunt. Sits between the shot path (ctl_trigger) and the duck

---
 rtl/ctl_round_if.sv | 29 ++
 rtl/ctl_round.sv | 164 ++++++++++++++++
 tb/tb_ctl_round.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctl_round_if.sv
// ctl_round_if: bundle between the Duck Hunt sequencer and its neighbours.
// master drives the event pulses; slave (the sequencer) drives the HUD/duck controls.
interface ctl_round_if;
    logic        new_frame;
    logic        start;
    logic        shot_fired;
    logic        hit;
    logic        duck_done;
    logic        duck_spawn;
    logic        duck_escape;
    logic [1:0]  shots_left;
    logic [3:0]  duck_idx;
    logic [3:0]  hit_count;
    logic [7:0]  round_num;
    logic [19:0] score;
    logic        game_over;

    modport master (
        output new_frame, start, shot_fired, hit, duck_done,
        input  duck_spawn, duck_escape, shots_left, duck_idx,
        input  hit_count, round_num, score, game_over
    );

    modport slave (
        input  new_frame, start, shot_fired, hit, duck_done,
        output duck_spawn, duck_escape, shots_left, duck_idx,
        output hit_count, round_num, score, game_over
    );
endinterface

// File: rtl/ctl_round.sv
// ctl_round: Duck Hunt game sequencer.
// Spawns ducks, budgets shots, times escapes, tracks hits, rounds and score.
module ctl_round #(
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int ESCAPE_FRAMES   = 300,
    parameter int PAUSE_FRAMES    = 60,
    parameter int POINTS_PER_HIT  = 500
) (
    input logic        clk,
    input logic        rst,
    ctl_round_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FLYING,
        S_HIT_WAIT,
        S_ESCAPE,
        S_PAUSE,
        S_ROUND_END,
        S_GAME_OVER
    } state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic        spawn_q;
    logic        escape_q;
    logic        over_q;
    logic [1:0]  shots_q;
    logic [3:0]  idx_q;
    logic [3:0]  hits_q;
    logic [7:0]  round_q;
    logic [19:0] score_q;

    logic [20:0] score_sum;
    logic [19:0] score_d;
    logic [1:0]  shots_d;
    logic [7:0]  round_d;
    logic        esc_tick;
    logic        pause_tick;
    logic        hit_ev;

    // Score adds in 21 bits so a carry out clamps instead of wrapping.
    assign score_sum  = {1'b0, score_q} + 21'(POINTS_PER_HIT);
    assign score_d    = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    assign shots_d    = (shots_q == 2'd0) ? 2'd0 : shots_q - 2'd1;
    assign round_d    = (round_q == 8'hFF) ? 8'hFF : round_q + 8'd1;
    assign esc_tick   = bus.new_frame && (timer_q == 16'(ESCAPE_FRAMES - 1));
    assign pause_tick = bus.new_frame && (timer_q == 16'(PAUSE_FRAMES - 1));
    assign hit_ev     = bus.shot_fired && bus.hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            spawn_q  <= 1'b0;
            escape_q <= 1'b0;
            over_q   <= 1'b0;
            shots_q  <= '0;
            idx_q    <= '0;
            hits_q   <= '0;
            round_q  <= '0;
            score_q  <= '0;
        end else begin
            spawn_q <= 1'b0;
            if (bus.new_frame) timer_q <= timer_q + 16'd1;
            // Every transition below also clears the frame timer.
            unique case (state_q)
                S_IDLE, S_GAME_OVER: begin
                    if (bus.start) begin
                        round_q <= 8'd1;
                        score_q <= '0;
                        idx_q   <= '0;
                        hits_q  <= '0;
                        over_q  <= 1'b0;
                        shots_q <= 2'(SHOTS_PER_DUCK);
                        spawn_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    timer_q <= '0;
                    state_q <= S_FLYING;
                end
                S_FLYING: begin
                    if (hit_ev) begin
                        shots_q <= shots_d;
                        hits_q  <= hits_q + 4'd1;
                        score_q <= score_d;
                        timer_q <= '0;
                        state_q <= S_HIT_WAIT;
                    end else if (bus.shot_fired && shots_d == 2'd0) begin
                        shots_q  <= shots_d;
                        escape_q <= 1'b1;
                        timer_q  <= '0;
                        state_q  <= S_ESCAPE;
                    end else begin
                        if (bus.shot_fired) shots_q <= shots_d;
                        if (esc_tick) begin
                            escape_q <= 1'b1;
                            timer_q  <= '0;
                            state_q  <= S_ESCAPE;
                        end
                    end
                end
                S_HIT_WAIT: begin
                    if (bus.duck_done) begin
                        timer_q <= '0;
                        state_q <= S_PAUSE;
                    end
                end
                S_ESCAPE: begin
                    if (bus.duck_done) begin
                        escape_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pause_tick) begin
                        timer_q <= '0;
                        if (idx_q == 4'(DUCKS_PER_ROUND - 1)) begin
                            state_q <= S_ROUND_END;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            shots_q <= 2'(SHOTS_PER_DUCK);
                            spawn_q <= 1'b1;
                            state_q <= S_SPAWN;
                        end
                    end
                end
                S_ROUND_END: begin
                    if (pause_tick) begin
                        timer_q <= '0;
                        if (hits_q >= 4'(PASS_HITS)) begin
                            round_q <= round_d;
                            idx_q   <= '0;
                            hits_q  <= '0;
                            shots_q <= 2'(SHOTS_PER_DUCK);
                            spawn_q <= 1'b1;
                            state_q <= S_SPAWN;
                        end else begin
                            over_q  <= 1'b1;
                            state_q <= S_GAME_OVER;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.duck_spawn  = spawn_q;
    assign bus.duck_escape = escape_q;
    assign bus.shots_left  = shots_q;
    assign bus.duck_idx    = idx_q;
    assign bus.hit_count   = hits_q;
    assign bus.round_num   = round_q;
    assign bus.score       = score_q;
    assign bus.game_over   = over_q;
endmodule

// File: tb/tb_ctl_round.sv
// tb_ctl_round: scenario tasks for the Duck Hunt sequencer.
// Expected spawn/game-over snapshots are queued as ducks are played, then popped.
module tb_ctl_round;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    logic [40:0] exp_q[$];
    int   m_idx, m_hits, m_round, m_score, m_shots;
    logic m_over;

    ctl_round_if bus ();
    ctl_round_if bus2 ();

    ctl_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ctl_round #(
        .POINTS_PER_HIT (300000),
        .PAUSE_FRAMES   (1)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [40:0] snap();
        return {bus.duck_spawn, bus.duck_escape, bus.game_over,
                bus.shots_left, bus.duck_idx, bus.hit_count,
                bus.round_num, bus.score};
    endfunction

    function automatic logic [40:0] mk(logic sp, logic es, logic go,
                                       int sh, int ix, int hc,
                                       int rn, int sc);
        return {sp, es, go, 2'(sh), 4'(ix), 4'(hc), 8'(rn), 20'(sc)};
    endfunction

    task automatic fire(logic h);
        bus.shot_fired = 1'b1;
        bus.hit = h;
        @(negedge clk);
        bus.shot_fired = 1'b0;
        bus.hit = 1'b0;
    endtask

    task automatic done();
        bus.duck_done = 1'b1;
        @(negedge clk);
        bus.duck_done = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic frames(int n);
        bus.new_frame = 1'b1;
        repeat (n) @(negedge clk);
        bus.new_frame = 1'b0;
    endtask

    task automatic run_until(logic want_over, int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i <= max && !ok; i++) begin
            ok = want_over ? bus.game_over : bus.duck_spawn;
            if (!ok && i < max) begin
                bus.new_frame = 1'b1;
                @(negedge clk);
            end
        end
        bus.new_frame = 1'b0;
    endtask

    // Plays one duck from its SPAWN cycle and queues the next expected snapshot.
    task automatic do_duck(logic h);
        @(negedge clk);
        if (h) begin
            fire(1'b1);
            m_hits++;
            m_score = (m_score + 500 > 'hFFFFF) ? 'hFFFFF : m_score + 500;
            m_shots = 2;
        end else begin
            repeat (3) fire(1'b0);
            m_shots = 0;
        end
        done();
        if (m_idx == 9) begin
            if (m_hits >= 6) begin
                m_round++;
                m_idx = 0;
                m_hits = 0;
                exp_q.push_back(mk(1, 0, 0, 3, m_idx, m_hits, m_round, m_score));
            end else begin
                m_over = 1'b1;
                exp_q.push_back(mk(0, 0, 1, m_shots, m_idx, m_hits, m_round, m_score));
            end
        end else begin
            m_idx++;
            exp_q.push_back(mk(1, 0, 0, 3, m_idx, m_hits, m_round, m_score));
        end
    endtask

    task automatic test_reset();
        logic [40:0] e;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (snap() !== e) $display("FAIL reset_init got %h want %h", snap(), e);
        else n_pass++;
        rst = 1'b1;
        go();
        e = mk(1, 0, 0, 3, 0, 0, 1, 0);
        n_total++;
        if (snap() !== e) $display("FAIL first_spawn got %h want %h", snap(), e);
        else n_pass++;
        @(negedge clk);
        frames(5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (snap() !== e) $display("FAIL reset_async got %h want %h", snap(), e);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        frames(5);
        n_total++;
        if (snap() !== e) $display("FAIL reset_idle got %h want %h", snap(), e);
        else n_pass++;
    endtask

    task automatic test_hit();
        logic [40:0] e;
        go();
        e = mk(1, 0, 0, 3, 0, 0, 1, 0);
        n_total++;
        if (snap() !== e) $display("FAIL start_spawn got %h want %h", snap(), e);
        else n_pass++;
        @(negedge clk);
        e = mk(0, 0, 0, 3, 0, 0, 1, 0);
        n_total++;
        if (snap() !== e) $display("FAIL spawn_pulse got %h want %h", snap(), e);
        else n_pass++;
        fire(1'b1);
        e = mk(0, 0, 0, 2, 0, 1, 1, 500);
        n_total++;
        if (snap() !== e) $display("FAIL hit got %h want %h", snap(), e);
        else n_pass++;
        fire(1'b1);
        n_total++;
        if (snap() !== e) $display("FAIL shot_in_hitwait got %h want %h", snap(), e);
        else n_pass++;
        done();
        exp_q.push_back(mk(1, 0, 0, 3, 1, 1, 1, 500));
        frames(59);
        n_total++;
        if (snap() !== e) $display("FAIL pause_59 got %h want %h", snap(), e);
        else n_pass++;
        frames(1);
        e = exp_q.pop_front();
        n_total++;
        if (snap() !== e) $display("FAIL pause_60 got %h want %h", snap(), e);
        else n_pass++;
    endtask

    task automatic test_miss();
        logic [40:0] e;
        logic ok;
        @(negedge clk);
        fire(1'b0);
        fire(1'b0);
        e = mk(0, 0, 0, 1, 1, 1, 1, 500);
        n_total++;
        if (snap() !== e) $display("FAIL miss2 got %h want %h", snap(), e);
        else n_pass++;
        fire(1'b0);
        e = mk(0, 1, 0, 0, 1, 1, 1, 500);
        n_total++;
        if (snap() !== e) $display("FAIL miss3_escape got %h want %h", snap(), e);
        else n_pass++;
        fire(1'b0);
        n_total++;
        if (snap() !== e) $display("FAIL no_underflow got %h want %h", snap(), e);
        else n_pass++;
        done();
        e = mk(0, 0, 0, 0, 1, 1, 1, 500);
        n_total++;
        if (snap() !== e) $display("FAIL escape_drop got %h want %h", snap(), e);
        else n_pass++;
        exp_q.push_back(mk(1, 0, 0, 3, 2, 1, 1, 500));
        run_until(1'b0, 80, ok);
        e = exp_q.pop_front();
        n_total++;
        if (!ok || snap() !== e) $display("FAIL miss_respawn got %h want %h", snap(), e);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [40:0] e;
        logic ok;
        @(negedge clk);
        frames(299);
        e = mk(0, 0, 0, 3, 2, 1, 1, 500);
        n_total++;
        if (snap() !== e) $display("FAIL timeout_299 got %h want %h", snap(), e);
        else n_pass++;
        frames(1);
        e = mk(0, 1, 0, 3, 2, 1, 1, 500);
        n_total++;
        if (snap() !== e) $display("FAIL timeout_300 got %h want %h", snap(), e);
        else n_pass++;
        done();
        exp_q.push_back(mk(1, 0, 0, 3, 3, 1, 1, 500));
        run_until(1'b0, 80, ok);
        e = exp_q.pop_front();
        n_total++;
        if (!ok || snap() !== e) $display("FAIL timeout_respawn got %h want %h", snap(), e);
        else n_pass++;
        @(negedge clk);
        frames(299);
        bus.new_frame = 1'b1;
        fire(1'b1);
        bus.new_frame = 1'b0;
        e = mk(0, 0, 0, 2, 3, 2, 1, 1000);
        n_total++;
        if (snap() !== e) $display("FAIL hit_beats_timeout got %h want %h", snap(), e);
        else n_pass++;
        done();
        exp_q.push_back(mk(1, 0, 0, 3, 4, 2, 1, 1000));
        run_until(1'b0, 80, ok);
        e = exp_q.pop_front();
        n_total++;
        if (!ok || snap() !== e) $display("FAIL tie_respawn got %h want %h", snap(), e);
        else n_pass++;
    endtask

    task automatic test_ignored();
        logic [40:0] e;
        logic ok;
        @(negedge clk);
        bus.hit = 1'b1;
        bus.duck_done = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        bus.duck_done = 1'b0;
        bus.start = 1'b0;
        e = mk(0, 0, 0, 3, 4, 2, 1, 1000);
        n_total++;
        if (snap() !== e) $display("FAIL ignored_inputs got %h want %h", snap(), e);
        else n_pass++;
        fire(1'b1);
        e = mk(0, 0, 0, 2, 4, 3, 1, 1500);
        n_total++;
        if (snap() !== e) $display("FAIL hit_after_ignored got %h want %h", snap(), e);
        else n_pass++;
        done();
        exp_q.push_back(mk(1, 0, 0, 3, 5, 3, 1, 1500));
        run_until(1'b0, 80, ok);
        e = exp_q.pop_front();
        n_total++;
        if (!ok || snap() !== e) $display("FAIL ignored_respawn got %h want %h", snap(), e);
        else n_pass++;
    endtask

    task automatic test_rounds();
        logic [40:0] e;
        logic ok;
        logic h;
        m_idx = 5;
        m_hits = 3;
        m_round = 1;
        m_score = 1500;
        m_over = 1'b0;
        for (int k = 0; k < 15; k++) begin
            h = (m_round == 1) ? (m_idx < 8) : (m_idx < 5);
            do_duck(h);
            run_until(m_over, 200, ok);
            e = exp_q.pop_front();
            n_total++;
            if (!ok || snap() !== e)
                $display("FAIL round_duck%0d got %h want %h", k, snap(), e);
            else n_pass++;
        end
        e = mk(0, 0, 1, 0, 9, 5, 2, 5500);
        fire(1'b1);
        frames(70);
        n_total++;
        if (snap() !== e) $display("FAIL over_frozen got %h want %h", snap(), e);
        else n_pass++;
        go();
        e = mk(1, 0, 0, 3, 0, 0, 1, 0);
        n_total++;
        if (snap() !== e) $display("FAIL restart got %h want %h", snap(), e);
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [23:0] got;
        logic [23:0] want;
        int sc;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        sc = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus2.shot_fired = 1'b1;
            bus2.hit = 1'b1;
            @(negedge clk);
            bus2.shot_fired = 1'b0;
            bus2.hit = 1'b0;
            sc = (sc + 300000 > 'hFFFFF) ? 'hFFFFF : sc + 300000;
            got = {bus2.hit_count, bus2.score};
            want = {4'(k), 20'(sc)};
            n_total++;
            if (got !== want) $display("FAIL sat_hit%0d got %h want %h", k, got, want);
            else n_pass++;
            bus2.duck_done = 1'b1;
            @(negedge clk);
            bus2.duck_done = 1'b0;
            bus2.new_frame = 1'b1;
            @(negedge clk);
            bus2.new_frame = 1'b0;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b0;
        bus.new_frame = 1'b0;
        bus.start = 1'b0;
        bus.shot_fired = 1'b0;
        bus.hit = 1'b0;
        bus.duck_done = 1'b0;
        bus2.new_frame = 1'b0;
        bus2.start = 1'b0;
        bus2.shot_fired = 1'b0;
        bus2.hit = 1'b0;
        bus2.duck_done = 1'b0;
        test_reset();
        test_hit();
        test_miss();
        test_timeout();
        test_ignored();
        test_rounds();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
